// File: rtl/dg0045_call_stack.sv
// dg0045_call_stack: parametrised return-address stack with occupancy count, overflow policy and sticky error flags
module dg0045_call_stack #(
  parameter int AW = 10,
  parameter int DEPTH = 5,
  parameter int OVF_MODE = 0,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  input  logic          clr_err,
  output logic [AW-1:0] top,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);
  logic [AW-1:0] entry_q [DEPTH];
  logic [AW-1:0] entry_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          ovf_ev, udf_ev;
  logic          is_empty, is_full;

  assign is_empty = count_q == '0;
  assign is_full  = count_q == CW'(DEPTH);

  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    ovf_ev  = 1'b0;
    udf_ev  = 1'b0;
    if (push && pop) begin
      entry_d[0] = push_data;
      count_d    = is_empty ? CW'(1) : count_q;
    end else if (push) begin
      ovf_ev = is_full;
      if (!is_full || OVF_MODE == 0) begin
        for (int i = DEPTH - 1; i > 0; i--) entry_d[i] = entry_q[i-1];
        entry_d[0] = push_data;
        count_d    = is_full ? count_q : count_q + CW'(1);
      end
    end else if (pop) begin
      udf_ev = is_empty;
      if (!is_empty) begin
        for (int i = 0; i < DEPTH - 1; i++) entry_d[i] = entry_q[i+1];
        entry_d[DEPTH-1] = '0;
        count_d          = count_q - CW'(1);
      end
    end
    // an error event in the same cycle as clr_err leaves its flag set
    ovf_d = ovf_ev | (ovf_q & ~clr_err);
    udf_d = udf_ev | (udf_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      entry_q <= entry_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign top       = entry_q[0];
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = udf_q;
endmodule

// File: tb/tb_dg0045_call_stack.sv
// tb_dg0045_call_stack: drives both overflow policies side by side against a queue-based stack model
module tb_dg0045_call_stack;
  localparam int AW = 10;
  localparam int DEPTH = 5;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [AW-1:0] top;
    logic [CW-1:0] cnt;
    logic          emp;
    logic          ful;
    logic          ovf;
    logic          udf;
  } exp_t;

  logic          clk = 1'b0;
  logic          RESET = 1'b0;
  logic          push = 1'b0, pop = 1'b0, clr_err = 1'b0;
  logic [AW-1:0] push_data = '0;
  logic [AW-1:0] top_w [2];
  logic [CW-1:0] cnt_w [2];
  logic          emp_w [2], ful_w [2], ovf_w [2], udf_w [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dg0045_call_stack #(.AW(AW), .DEPTH(DEPTH), .OVF_MODE(g)) u_dut (
      .clk(clk), .RESET(RESET), .push(push), .pop(pop), .push_data(push_data),
      .clr_err(clr_err), .top(top_w[g]), .count(cnt_w[g]), .empty(emp_w[g]),
      .full(ful_w[g]), .overflow(ovf_w[g]), .underflow(udf_w[g]));
  end

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  exp_t [1:0] exp_q[$];

  logic [AW-1:0] stk0[$];
  logic [AW-1:0] stk1[$];
  bit            m_ovf [2];
  bit            m_udf [2];

  task automatic check(input string name, input int m, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s mode%0d: got 0x%0h expected 0x%0h at %0t", name, m, act, exp, $time);
    end
  endtask

  function automatic exp_t [1:0] snapshot();
    exp_t [1:0] e;
    logic [AW-1:0] s[$];
    for (int m = 0; m < 2; m++) begin
      if (m == 0) s = stk0; else s = stk1;
      e[m].top = s.size() > 0 ? s[0] : '0;
      e[m].cnt = CW'(s.size());
      e[m].emp = s.size() == 0;
      e[m].ful = s.size() == DEPTH;
      e[m].ovf = m_ovf[m];
      e[m].udf = m_udf[m];
    end
    return e;
  endfunction

  // reference: a LIFO queue whose front is the top of stack
  task automatic model_step(input bit p, input bit q, input logic [AW-1:0] d, input bit c);
    logic [AW-1:0] s[$];
    bit ov, un;
    for (int m = 0; m < 2; m++) begin
      if (m == 0) s = stk0; else s = stk1;
      ov = 1'b0;
      un = 1'b0;
      if (p && q) begin
        if (s.size() == 0) s.push_front(d); else s[0] = d;
      end else if (p) begin
        if (s.size() == DEPTH) begin
          ov = 1'b1;
          if (m == 0) begin
            void'(s.pop_back());
            s.push_front(d);
          end
        end else s.push_front(d);
      end else if (q) begin
        if (s.size() == 0) un = 1'b1; else void'(s.pop_front());
      end
      m_ovf[m] = (m_ovf[m] && !c) || ov;
      m_udf[m] = (m_udf[m] && !c) || un;
      if (m == 0) stk0 = s; else stk1 = s;
    end
  endtask

  task automatic op(input bit p, input bit q, input logic [AW-1:0] d, input bit c);
    push = p;
    pop = q;
    push_data = d;
    clr_err = c;
    @(posedge clk);
    model_step(p, q, d, c);
    exp_q.push_back(snapshot());
    @(negedge clk);
    push = 1'b0;
    pop = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic do_reset();
    #2 RESET = 1'b0;
    stk0.delete();
    stk1.delete();
    m_ovf = '{0, 0};
    m_udf = '{0, 0};
    #1;
    for (int m = 0; m < 2; m++) begin
      check("async_rst_top", m, int'(top_w[m]), 0);
      check("async_rst_cnt", m, int'(cnt_w[m]), 0);
    end
    exp_q.push_back(snapshot());
    @(negedge clk);
    #1 RESET = 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t [1:0] e;
      e = exp_q.pop_front();
      for (int m = 0; m < 2; m++) begin
        check("top", m, int'(top_w[m]), int'(e[m].top));
        check("count", m, int'(cnt_w[m]), int'(e[m].cnt));
        check("empty", m, int'(emp_w[m]), int'(e[m].emp));
        check("full", m, int'(ful_w[m]), int'(e[m].ful));
        check("overflow", m, int'(ovf_w[m]), int'(e[m].ovf));
        check("underflow", m, int'(udf_w[m]), int'(e[m].udf));
      end
    end
  end

  initial begin
    do_reset();
    op(1, 0, 10'h101, 0);
    op(1, 0, 10'h202, 0);
    op(1, 0, 10'h303, 0);
    repeat (4) op(0, 1, '0, 0);
    do_reset();
    for (int i = 1; i <= 6; i++) op(1, 0, AW'(i), 0);
    repeat (6) op(0, 1, '0, 0);
    do_reset();
    op(1, 0, 10'h050, 0);
    op(1, 0, 10'h0A0, 0);
    op(1, 1, 10'h3FF, 0);
    op(0, 1, '0, 0);
    do_reset();
    op(0, 1, '0, 1);
    op(0, 0, '0, 1);
    op(1, 1, 10'h2AA, 0);
    op(1, 0, 10'h155, 0);
    op(1, 0, 10'h155, 0);
    do_reset();
    op(0, 1, '0, 0);
    op(0, 1, '0, 0);
    for (int i = 0; i < 600; i++) begin
      int r;
      bit pushy;
      pushy = (i / 40) % 2 == 0;
      r = int'($urandom_range(0, 9));
      if (r < (pushy ? 5 : 2)) op(1, 0, AW'($urandom_range(0, 1023)), $urandom_range(0, 7) == 0);
      else if (r < 7) op(0, 1, '0, $urandom_range(0, 7) == 0);
      else if (r < 9) op(1, 1, AW'($urandom_range(0, 1023)), $urandom_range(0, 7) == 0);
      else op(0, 0, '0, $urandom_range(0, 3) == 0);
      if (i == 300) do_reset();
    end
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
